// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: datapath width, register index
// width, write-back select encoding and the misaligned-access check.
package mips_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic WB_ALU = 1'b0;
   localparam logic WB_MEM = 1'b1;

   function automatic logic misaligned(input logic [1:0] lo,
                                       input logic       acc);
      return (lo != 2'b00) && acc;
   endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
// Ports: clk, we (write enable), addr (word index), wd (write data), rd (read data).
module data_memory #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wd;
   end

   assign rd = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, word load/store to data_memory, MEM/WB register
// and write-back mux. Inputs are E-stage controls/data plus FlushM; outputs
// are M-stage hazard/forwarding signals and W-stage register-file signals.
module memory_stage #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int DEPTH  = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            RegWriteE,
   input  logic                            MemtoRegE,
   input  logic                            MemWriteE,
   input  logic [DATA_W-1:0]               ALUOutE,
   input  logic [DATA_W-1:0]               WriteDataE,
   input  logic [mips_pkg::REG_ADDR_W-1:0] WriteRegE,
   input  logic                            FlushM,
   output logic                            RegWriteM,
   output logic                            MemtoRegM,
   output logic [mips_pkg::REG_ADDR_W-1:0] WriteRegM,
   output logic [DATA_W-1:0]               ALUOutM,
   output logic                            RegWriteW,
   output logic [mips_pkg::REG_ADDR_W-1:0] WriteRegW,
   output logic [DATA_W-1:0]               ResultW,
   output logic                            AddrErrW
);

   import mips_pkg::*;

   localparam int ADDR_W = $clog2(DEPTH);

   logic              MemWriteM;
   logic [DATA_W-1:0] WriteDataM;
   logic              MemtoRegW;
   logic [DATA_W-1:0] ALUOutW;
   logic [DATA_W-1:0] ReadDataW;
   logic [DATA_W-1:0] rdM;
   logic [ADDR_W-1:0] idxM;
   logic              misM;
   logic              weM;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ALUOutM    <= '0;
         WriteDataM <= '0;
         WriteRegM  <= '0;
      end else begin
         RegWriteM  <= RegWriteE & ~FlushM;
         MemtoRegM  <= MemtoRegE & ~FlushM;
         MemWriteM  <= MemWriteE & ~FlushM;
         ALUOutM    <= ALUOutE;
         WriteDataM <= WriteDataE;
         WriteRegM  <= WriteRegE;
      end
   end

   // Upper address bits are dropped, so addresses alias modulo DEPTH*4.
   assign idxM = ALUOutM[ADDR_W+1:2];
   assign misM = misaligned(ALUOutM[1:0], MemWriteM | MemtoRegM);
   // Gating on rst keeps a store from landing at an edge held in reset.
   assign weM  = MemWriteM & ~misM & ~rst;

   data_memory #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_dmem (
      .clk (clk),
      .we  (weM),
      .addr(idxM),
      .wd  (WriteDataM),
      .rd  (rdM)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ALUOutW   <= '0;
         ReadDataW <= '0;
         WriteRegW <= '0;
         AddrErrW  <= 1'b0;
      end else begin
         // A misaligned access never writes the register file.
         RegWriteW <= RegWriteM & ~misM;
         MemtoRegW <= MemtoRegM;
         ALUOutW   <= ALUOutM;
         ReadDataW <= rdM;
         WriteRegW <= WriteRegM;
         AddrErrW  <= misM;
      end
   end

   assign ResultW = (MemtoRegW == WB_MEM) ? ReadDataW : ALUOutW;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the 5-stage MIPS core.
- Captures execute results in an EX/MEM register and performs word loads and stores against an internal data memory.
- Captures the load/ALU result in a MEM/WB register and produces the write-back result.
- Provides ALUOutM and ResultW as the forwarding sources consumed by the execute stage's forwarding muxes.

Parameters:
- DATA_W, 32, datapath and memory word width.
- DEPTH, 64, data memory size in words (power of two).
- ADDR_W, clog2(DEPTH), local only, word-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- RegWriteE  in  1  execute-stage register-write control.
- MemtoRegE  in  1  execute-stage load select.
- MemWriteE  in  1  execute-stage store enable.
- ALUOutE  in  DATA_W  execute ALU result (byte address for loads/stores).
- WriteDataE  in  DATA_W  forwarded store data from execute.
- WriteRegE  in  5  destination register from execute.
- FlushM  in  1  synchronous bubble insert into EX/MEM.
- RegWriteM  out  1  registered; used by the hazard unit.
- MemtoRegM  out  1  registered.
- WriteRegM  out  5  registered; used by the hazard unit.
- ALUOutM  out  DATA_W  registered; execute forwarding source.
- RegWriteW  out  1  registered; to register file.
- WriteRegW  out  5  registered; to register file.
- ResultW  out  DATA_W  combinational write-back mux output; to register file and execute forwarding.
- AddrErrW  out  1  registered misaligned-access flag.

Behaviour:
- Reset (async, rst=1): every EX/MEM and MEM/WB register clears to 0 immediately, with no clock needed.
  - Outputs RegWriteM, MemtoRegM, WriteRegM, ALUOutM, RegWriteW, WriteRegW and AddrErrW are 0.
  - ResultW is 0 because ALUOutW=0 and MemtoRegW=0.
  - Memory contents are not reset and are retained.
  - While rst=1 no memory write occurs.
- EX/MEM register: on each rising edge it captures RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE and WriteRegE.
  - FlushM=1 captures zeros for the control bits (RegWrite, MemtoReg, MemWrite).
  - Data fields are don't-care under flush but are captured normally.
- Address: word index = ALUOutM[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- Misalign: misM = (ALUOutM[1:0] != 0) and (MemWriteM or MemtoRegM).
- Store: at a rising edge with MemWriteM=1 and misM=0, mem[idx] <= WriteDataM.
  - A misaligned store is suppressed; memory is unchanged.
- Load: read is combinational from mem[idx] during M and is captured into ReadDataW at the edge.
  - A misaligned load still reads the word (low bits dropped) but flags AddrErrW.
- MEM/WB register: captures RegWriteM, MemtoRegM, ALUOutM, ReadData, WriteRegM, and AddrErrW <= misM.
  - If misM=1, RegWriteW is forced to 0, so a bad load never writes the register file.
- ResultW = MemtoRegW ? ReadDataW : ALUOutW.
- Latency: an instruction in E appears at the M outputs 1 cycle later and at the W outputs 2 cycles later.
- Store then load to the same address in consecutive cycles: the load reads the new data, because the write commits at the edge that ends the store's M cycle.
- Store to an address whose load is in W the same cycle: ReadDataW is unaffected (already registered).
- No stall input; this stage never stalls.
- Reset asserted mid-operation aborts any in-flight store at once. A store whose edge coincides with rst=1 is dropped.

Decomposition:
- Shared package (mips_pkg): DATA_W default, REG_ADDR_W=5, and WB-select encoding constants.
- One sub-module, data_memory: parameters DATA_W and DEPTH; ports clk, we, addr, wd, rd; synchronous write, asynchronous read, no reset.
- The pipeline registers and write-back mux stay in memory_stage.

Test Plan:
- Reset: drive RegWriteE=1, ALUOutE=0x10, then assert rst mid-cycle -> all M and W outputs read 0 immediately, and ResultW=0.
- Store/load: sw 0xDEADBEEF to 0x08, next cycle lw from 0x08 with WriteRegE=5 -> two cycles after the lw enters, RegWriteW=1, WriteRegW=5, ResultW=0xDEADBEEF.
- ALU pass-through: ALUOutE=0x1234, MemtoRegE=0, RegWriteE=1 -> ALUOutM=0x1234 after 1 cycle, ResultW=0x1234 after 2 cycles.
- Misaligned store: sw 0x55 to 0x0A -> memory word 2 unchanged (a later lw 0x08 returns the prior value), AddrErrW=1 one cycle after M.
- Misaligned load: lw from 0x09 with RegWriteE=1 -> RegWriteW=0 and AddrErrW=1.
- Flush and alias: FlushM=1 with MemWriteE=1 at 0x04 -> no write, RegWriteM=0. Separately, sw to 0x100 with DEPTH=64 -> lw 0x000 returns the stored value.
